// File: rtl/bt_rx_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : bt_rx_decoder
// Purpose  : Receive-side 8N1 UART decoder for the Bluetooth module link.
//            Turns the BT_Rx line into bytes, recognises the pattern digits
//            '1'..'4' and the "OK\r" / "CONNECT\r" response lines, and
//            produces registered outputs and one-cycle strobes.
//            BIT_CYCLES must be even and >= 8.
// Revision : 1.0  initial release
// ============================================================================
module bt_rx_decoder #(
    parameter int BIT_CYCLES = 1000
) (
    input  logic       CLOCK_10,
    input  logic       reset,
    input  logic       BT_Rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic [2:0] Pattern,
    output logic       pattern_stb,
    output logic       ok_stb,
    output logic       connect_stb
);

    // Baud counter runs 0..BIT_CYCLES-1, so ceil(log2(BIT_CYCLES)) bits suffice
    localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

    // Terminal counts: a full bit period, and half a period for the start bit
    localparam logic [CNT_W-1:0] c_FULL = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_HALF = CNT_W'(BIT_CYCLES / 2 - 1);

    localparam logic [7:0] c_CR       = 8'h0D;
    localparam logic [7:0] c_DIGIT_LO = 8'h31;
    localparam logic [7:0] c_DIGIT_HI = 8'h34;

    localparam logic [1:0] c_OK_LEN   = 2'd2;
    localparam logic [2:0] c_CONN_LEN = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Keyword character tables
    // ------------------------------------------------------------------
    function automatic logic [7:0] f_ok_char(input logic [1:0] idx);
        logic [7:0] ch;
        case (idx)
            2'd0:    ch = 8'h4F;   // 'O'
            2'd1:    ch = 8'h4B;   // 'K'
            default: ch = 8'h00;
        endcase
        return ch;
    endfunction

    function automatic logic [7:0] f_conn_char(input logic [2:0] idx);
        logic [7:0] ch;
        case (idx)
            3'd0:    ch = 8'h43;   // 'C'
            3'd1:    ch = 8'h4F;   // 'O'
            3'd2:    ch = 8'h4E;   // 'N'
            3'd3:    ch = 8'h4E;   // 'N'
            3'd4:    ch = 8'h45;   // 'E'
            3'd5:    ch = 8'h43;   // 'C'
            3'd6:    ch = 8'h54;   // 'T'
            default: ch = 8'h00;
        endcase
        return ch;
    endfunction

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic             r_rx_meta;
    logic             r_rx_s;
    state_t           r_state;
    logic [CNT_W-1:0] r_baud_cnt;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    logic [1:0]       r_ok_idx;
    logic [2:0]       r_conn_idx;

    logic             w_baud_full;
    logic             w_baud_half;
    logic             w_is_digit;
    logic             w_ok_hit;
    logic [1:0]       w_ok_idx_nxt;
    logic             w_conn_hit;
    logic [2:0]       w_conn_idx_nxt;

    // Two-flop synchronizer for the asynchronous line; idles high
    always_ff @(posedge CLOCK_10) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= BT_Rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    assign w_baud_full = (r_baud_cnt == c_FULL);
    assign w_baud_half = (r_baud_cnt == c_HALF);

    // Receiver FSM: start detect, mid-bit sampling, stop check, break wait
    always_ff @(posedge CLOCK_10) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'h00;
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_baud_cnt <= '0;
                    r_bit_cnt  <= 3'd0;
                    if (!r_rx_s) begin
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_baud_half) begin
                        r_baud_cnt <= '0;
                        // A high line at mid-start is a glitch, not a frame
                        r_state    <= r_rx_s ? S_IDLE : S_DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_baud_full) begin
                        r_baud_cnt <= '0;
                        r_shift    <= {r_rx_s, r_shift[7:1]};
                        if (r_bit_cnt == 3'd7) begin
                            r_bit_cnt <= 3'd0;
                            r_state   <= S_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_baud_full) begin
                        r_baud_cnt <= '0;
                        if (r_rx_s) begin
                            rx_data  <= r_shift;
                            rx_valid <= 1'b1;
                            r_state  <= S_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            r_state   <= S_BREAK;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                S_BREAK: begin
                    r_baud_cnt <= '0;
                    r_bit_cnt  <= 3'd0;
                    if (r_rx_s) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_baud_cnt <= '0;
                    r_bit_cnt  <= 3'd0;
                end
            endcase
        end
    end

    // Next-index logic for both keyword matchers, evaluated on the new byte
    always_comb begin
        w_is_digit     = (rx_data >= c_DIGIT_LO) && (rx_data <= c_DIGIT_HI);

        w_ok_hit       = 1'b0;
        w_ok_idx_nxt   = r_ok_idx;
        if ((r_ok_idx == c_OK_LEN) && (rx_data == c_CR)) begin
            w_ok_hit     = 1'b1;
            w_ok_idx_nxt = 2'd0;
        end else if ((r_ok_idx < c_OK_LEN) && (rx_data == f_ok_char(r_ok_idx))) begin
            w_ok_idx_nxt = r_ok_idx + 2'd1;
        end else begin
            // Restart only on the first keyword character, no deeper overlap
            w_ok_idx_nxt = (rx_data == f_ok_char(2'd0)) ? 2'd1 : 2'd0;
        end

        w_conn_hit     = 1'b0;
        w_conn_idx_nxt = r_conn_idx;
        if ((r_conn_idx == c_CONN_LEN) && (rx_data == c_CR)) begin
            w_conn_hit     = 1'b1;
            w_conn_idx_nxt = 3'd0;
        end else if ((r_conn_idx < c_CONN_LEN) && (rx_data == f_conn_char(r_conn_idx))) begin
            w_conn_idx_nxt = r_conn_idx + 3'd1;
        end else begin
            w_conn_idx_nxt = (rx_data == f_conn_char(3'd0)) ? 3'd1 : 3'd0;
        end
    end

    // Byte interpretation: pattern select, keyword strobes, index update
    always_ff @(posedge CLOCK_10) begin
        if (reset) begin
            Pattern     <= 3'd0;
            pattern_stb <= 1'b0;
            ok_stb      <= 1'b0;
            connect_stb <= 1'b0;
            r_ok_idx    <= 2'd0;
            r_conn_idx  <= 3'd0;
        end else begin
            pattern_stb <= 1'b0;
            ok_stb      <= 1'b0;
            connect_stb <= 1'b0;
            if (frame_err) begin
                // A corrupted byte breaks any partially matched line
                r_ok_idx   <= 2'd0;
                r_conn_idx <= 3'd0;
            end else if (rx_valid) begin
                r_ok_idx    <= w_ok_idx_nxt;
                r_conn_idx  <= w_conn_idx_nxt;
                ok_stb      <= w_ok_hit;
                connect_stb <= w_conn_hit;
                if (w_is_digit) begin
                    // '1'..'4' map to 1..4 via the low three bits
                    Pattern     <= rx_data[2:0];
                    pattern_stb <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bt_rx_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_bt_rx_decoder
// Purpose  : Self-checking bench for bt_rx_decoder (reduced bit period).
// Revision : 1.0  initial release
// ============================================================================
module tb_bt_rx_decoder;

    localparam int B = 100;

    logic       clk = 1'b0;
    logic       rst;
    logic       line;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, pattern_stb, ok_stb, connect_stb;
    logic [2:0] Pattern;

    bt_rx_decoder #(.BIT_CYCLES(B)) dut (
        .CLOCK_10    (clk),
        .reset       (rst),
        .BT_Rx       (line),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .frame_err   (frame_err),
        .Pattern     (Pattern),
        .pattern_stb (pattern_stb),
        .ok_stb      (ok_stb),
        .connect_stb (connect_stb)
    );

    always #50 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed event counters, sampled on the falling edge
    int n_valid = 0, n_ferr = 0, n_pstb = 0, n_ok = 0, n_conn = 0;
    int n_bad_tim = 0, n_coinc = 0, valid_cyc = 0;
    logic [7:0] last_data = 8'h00;
    logic prev_valid = 1'b0;

    always @(negedge clk) begin
        if (rx_valid) begin
            n_valid++;
            last_data = rx_data;
            valid_cyc = cyc;
        end
        if (frame_err)   n_ferr++;
        if (pattern_stb) n_pstb++;
        if (ok_stb)      n_ok++;
        if (connect_stb) n_conn++;
        if ((pattern_stb || ok_stb || connect_stb) && !prev_valid) n_bad_tim++;
        if ((ok_stb && connect_stb) || (pattern_stb && (ok_stb || connect_stb))) n_coinc++;
        prev_valid = rx_valid;
    end

    // Reference model state
    int vectors = 0, miscompares = 0;
    int e_valid = 0, e_ferr = 0, e_pstb = 0, e_ok = 0, e_conn = 0;
    int e_pattern = 0;
    logic [7:0] e_data = 8'h00;
    int ok_i = 0, cn_i = 0;
    byte kw_ok[2] = '{8'h4F, 8'h4B};
    byte kw_cn[7] = '{8'h43, 8'h4F, 8'h4E, 8'h4E, 8'h45, 8'h43, 8'h54};
    byte alpha[12] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h4F, 8'h4B,
                       8'h43, 8'h4E, 8'h45, 8'h54, 8'h0D, 8'h41};

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic model_byte(input byte b);
        e_valid++;
        e_data = b;
        if (b >= 8'h31 && b <= 8'h34) begin
            e_pattern = int'(b) - 'h30;
            e_pstb++;
        end
        if (ok_i == 2 && b == 8'h0D) begin e_ok++; ok_i = 0; end
        else if (ok_i < 2 && b == kw_ok[ok_i]) ok_i++;
        else ok_i = (b == kw_ok[0]) ? 1 : 0;
        if (cn_i == 7 && b == 8'h0D) begin e_conn++; cn_i = 0; end
        else if (cn_i < 7 && b == kw_cn[cn_i]) cn_i++;
        else cn_i = (b == kw_cn[0]) ? 1 : 0;
    endtask

    task automatic hold(input logic v, input int n);
        line = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input byte b, input int p, input logic stop_bit);
        hold(1'b0, p);
        for (int i = 0; i < 8; i++) hold(b[i], p);
        hold(stop_bit, p);
    endtask

    task automatic send_byte(input byte b, input int p);
        send_frame(b, p, 1'b1);
        hold(1'b1, 20);
        model_byte(b);
    endtask

    task automatic send_line(input string s, input int p);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], p);
        send_byte(8'h0D, p);
        hold(1'b1, B);
    endtask

    task automatic check_counts(input string tag);
        check({tag, " valid"}, n_valid, e_valid);
        check({tag, " ferr"},  n_ferr,  e_ferr);
        check({tag, " pstb"},  n_pstb,  e_pstb);
        check({tag, " ok"},    n_ok,    e_ok);
        check({tag, " conn"},  n_conn,  e_conn);
        check({tag, " pattern"}, int'(Pattern), e_pattern);
    endtask

    initial begin
        int n0;
        byte b;
        rst  = 1'b1;
        line = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("reset rx_data", int'(rx_data), 0);
        check("reset pattern", int'(Pattern), 0);
        check("reset strobes", int'({rx_valid, frame_err, pattern_stb, ok_stb, connect_stb}), 0);
        rst = 1'b0;
        hold(1'b1, 10);

        // Single digits with ideal timing, including first-byte latency
        n0 = cyc;
        send_byte(8'h31, B);
        check("digit1 latency", valid_cyc, n0 + 2 + B/2 + 9*B + 1);
        check("digit1 data", int'(last_data), 'h31);
        check_counts("digit1");
        check("digit1 pattern abs", int'(Pattern), 1);
        send_byte(8'h34, B);
        check("digit4 pattern abs", int'(Pattern), 4);
        check_counts("digit4");

        // Keyword lines
        send_line("OK", B);
        check("ok once", n_ok, 1);
        check_counts("okline");
        send_line("CONNECT", B);
        check("connect once", n_conn, 1);
        check_counts("connline");
        send_line("CCONNECT", B);
        check("cconnect", n_conn, 2);
        check_counts("cconnline");
        send_line("CONNEXT", B);
        check("connext none", n_conn, 2);
        check_counts("connext");

        // Framing error with a held-low line, then a clean OK line
        send_frame(8'h41, B, 1'b0);
        hold(1'b0, 3*B);
        hold(1'b1, B);
        e_ferr++; ok_i = 0; cn_i = 0;
        check("ferr count", n_ferr, 1);
        send_line("OK", B);
        check("ok after ferr", n_ok, 2);
        check_counts("ferr");

        // Glitch shorter than half a bit
        hold(1'b0, 30);
        hold(1'b1, 12*B);
        check_counts("glitch");

        // Baud tolerance
        send_byte(8'h55, B + 3*B/100);
        check("slow 55", int'(last_data), 'h55);
        send_byte(8'hAA, B + 3*B/100);
        check("slow AA", int'(last_data), 'hAA);
        send_byte(8'h55, B - 3*B/100);
        check("fast 55", int'(last_data), 'h55);
        send_byte(8'hAA, B - 3*B/100);
        check("fast AA", int'(last_data), 'hAA);
        check_counts("tolerance");

        // Reset during data bit 4 of 0x32
        b = 8'h32;
        hold(1'b0, B);
        for (int i = 0; i < 4; i++) hold(b[i], B);
        hold(b[4], B/2);
        rst = 1'b1;
        hold(1'b1, 4);
        rst = 1'b0;
        e_pattern = 0; e_data = 8'h00; ok_i = 0; cn_i = 0;
        hold(1'b1, 12*B);
        check("midreset rx_data", int'(rx_data), 0);
        check_counts("midreset");
        send_byte(8'h33, B);
        check("after reset pattern abs", int'(Pattern), 3);
        check_counts("after reset");

        // Randomized byte stream at jittered bit periods
        for (int k = 0; k < 14; k++) begin
            b = alpha[$urandom_range(0, 11)];
            send_byte(b, $urandom_range(B - 3, B + 3));
            check("random data", int'(last_data), int'(e_data));
        end
        hold(1'b1, B);
        check_counts("random");
        check("strobe timing", n_bad_tim, 0);
        check("strobe coincidence", n_coinc, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
